// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, fault codes
// and FSM state encodings.
package load_store_unit_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
   localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_RESP   = 2'b10
   } lsu_state_t;

endpackage

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the load/store unit: store strobes and replicated
// write data, load extraction with sign/zero extension, and access legality.
module load_store_unit_align
   import load_store_unit_pkg::*;
(
   input  logic        store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  wstrb,
   output logic [31:0] wdata_rep,
   output logic [31:0] load_ext,
   output logic        misalign,
   output logic        illegal
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = rdata[{lane, 3'b000} +: 8];
   assign half_sel = rdata[{lane[1], 4'b0000} +: 16];

   always_comb begin
      wstrb     = '0;
      wdata_rep = wdata;
      load_ext  = '0;
      misalign  = 1'b0;
      illegal   = store ? (funct3 > 3'b010)
                        : (funct3 == 3'b011 || funct3[2:1] == 2'b11);

      case (funct3[1:0])
         2'b01:   misalign = lane[0];
         2'b10:   misalign = |lane;
         default: misalign = 1'b0;
      endcase

      if (store) begin
         case (funct3)
            F3_SB: begin
               wdata_rep = {4{wdata[7:0]}};
               wstrb     = 4'b0001 << lane;
            end
            F3_SH: begin
               wdata_rep = {2{wdata[15:0]}};
               wstrb     = 4'b0011 << lane;
            end
            F3_SW: begin
               wdata_rep = wdata;
               wstrb     = 4'b1111;
            end
            default: wstrb = '0;
         endcase
      end else begin
         case (funct3)
            F3_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_ext = rdata;
            F3_LBU:  load_ext = {24'h0, byte_sel};
            F3_LHU:  load_ext = {16'h0, half_sel};
            default: load_ext = '0;
         endcase
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory stage: registers one load/store, runs the req/ready handshake to
// memory with a bounded wait, and reports completion or fault to the core.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_IDLE   | waiting for req_valid; legality checked on the live request
//   ST_ACCESS | mem_req held with stable lanes until mem_ready or timeout
//   ST_RESP   | done pulse with fault code; req_valid ignored
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] load_data,
   output logic [1:0]      fault,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [3:0]      mem_wstrb,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ready
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   lsu_state_t      state_q, state_d;
   logic            store_q;
   logic [2:0]      f3_q;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] wdata_q;
   logic [CW-1:0]   cnt_q;
   logic [1:0]      fault_q, fault_d;
   logic [XLEN-1:0] load_q;

   logic            is_idle, in_access, timeout_hit;
   logic            a_store;
   logic [2:0]      a_f3;
   logic [1:0]      a_lane;
   logic [XLEN-1:0] a_wdata_in;
   logic [3:0]      a_wstrb;
   logic [XLEN-1:0] a_wdata_rep;
   logic [XLEN-1:0] a_load_ext;
   logic            a_misalign, a_illegal;

   assign is_idle   = (state_q == ST_IDLE);
   assign in_access = (state_q == ST_ACCESS);

   // One aligner serves both phases: live request for the legality check in
   // IDLE, registered request for lane steering during ACCESS.
   assign a_store    = is_idle ? req_store       : store_q;
   assign a_f3       = is_idle ? req_funct3      : f3_q;
   assign a_lane     = is_idle ? req_addr[1:0]   : addr_q[1:0];
   assign a_wdata_in = is_idle ? req_wdata       : wdata_q;

   load_store_unit_align u_align (
      .store     (a_store),
      .funct3    (a_f3),
      .lane      (a_lane),
      .wdata     (a_wdata_in),
      .rdata     (mem_rdata),
      .wstrb     (a_wstrb),
      .wdata_rep (a_wdata_rep),
      .load_ext  (a_load_ext),
      .misalign  (a_misalign),
      .illegal   (a_illegal)
   );

   // cnt_q counts completed ACCESS cycles, so the last allowed one is TIMEOUT-1.
   assign timeout_hit = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) >= TIMEOUT);

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (a_illegal) begin
                  state_d = ST_RESP;
                  fault_d = FLT_ILLEGAL;
               end else if (a_misalign) begin
                  state_d = ST_RESP;
                  fault_d = FLT_MISALIGN;
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (mem_ready) begin
               state_d = ST_RESP;
               fault_d = FLT_NONE;
            end else if (timeout_hit) begin
               state_d = ST_RESP;
               fault_d = FLT_TIMEOUT;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         store_q <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         fault_q <= FLT_NONE;
         load_q  <= '0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
         if (is_idle && req_valid) begin
            store_q <= req_store;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= '0;
         end else if (in_access && (cnt_q != {CW{1'b1}})) begin
            cnt_q <= cnt_q + CW'(1);
         end
         if (in_access && mem_ready && !store_q) begin
            load_q <= a_load_ext;
         end
      end
   end

   assign done      = (state_q == ST_RESP);
   assign stall     = req_valid & ~done;
   assign fault     = fault_q;
   assign load_data = load_q;

   assign mem_req   = in_access;
   assign mem_we    = in_access & store_q;
   assign mem_addr  = in_access ? {addr_q[XLEN-1:2], 2'b00} : '0;
   assign mem_wstrb = in_access ? a_wstrb : 4'b0000;
   assign mem_wdata = in_access ? a_wdata_rep : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, random
// requests and memory wait states, plus directed boundary cases.
module tb_load_store_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid, req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        stall, done;
   logic [31:0] load_data;
   logic [1:0]  fault;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   always #5 clk = ~clk;

   load_store_unit #(.XLEN(32), .TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .stall      (stall),
      .done       (done),
      .load_data  (load_data),
      .fault      (fault),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready)
   );

   typedef struct {
      logic [1:0]  flt;
      logic [31:0] ld;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } acc_t;

   resp_t       resp_q[$];
   acc_t        acc_q[$];
   resp_t       r_pop;
   acc_t        a_pop;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  ref_mem[64];
   logic [31:0] bus_mem[16];
   logic [31:0] exp_ld;
   int          cur_delay = 0;
   int          wait_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic set_word(input int idx, input logic [31:0] v);
      bus_mem[idx] = v;
      for (int i = 0; i < 4; i++) ref_mem[idx*4 + i] = 8'(v >> (8*i));
   endtask

   function automatic int ref_fault(input logic st, input logic [2:0] f3, input logic [31:0] a);
      int sz;
      sz = 1 << f3[1:0];
      if (st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 3;
      if ((a % sz) != 0) return 1;
      return 0;
   endfunction

   // Memory responder: ready after cur_delay wait states; random noise on
   // mem_ready/mem_rdata whenever no request is pending.
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            if (wait_cnt == cur_delay) begin
               mem_ready = 1'b1;
               mem_rdata = bus_mem[mem_addr[5:2]];
               if (mem_we)
                  for (int i = 0; i < 4; i++)
                     if (mem_wstrb[i]) bus_mem[mem_addr[5:2]][8*i +: 8] = mem_wdata[8*i +: 8];
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
            end
            wait_cnt++;
         end else begin
            wait_cnt  = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done) begin
         if (resp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 required no pending response");
         end else begin
            r_pop = resp_q.pop_front();
            chk("fault", 32'(fault), 32'(r_pop.flt));
            chk("load_data", load_data, r_pop.ld);
         end
      end
      if (rst_n && mem_req && mem_ready) begin
         if (acc_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_access: got mem_req at 0x%08h required none", mem_addr);
         end else begin
            a_pop = acc_q.pop_front();
            chk("mem_addr", mem_addr, a_pop.addr);
            chk("mem_we", 32'(mem_we), 32'(a_pop.we));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(a_pop.strb));
            if (a_pop.we) chk("mem_wdata", mem_wdata, a_pop.wdata);
         end
      end
   end

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] d, input int delay);
      int          sz, flt, lat, nreq_exp, cyc, nreq;
      logic [31:0] val;
      acc_t        a;
      resp_t       r;
      sz  = 1 << f3[1:0];
      flt = ref_fault(st, f3, addr);
      if (flt == 0 && delay >= TMO) flt = 2;
      if (flt == 0) begin
         a.addr  = addr & 32'hFFFF_FFFC;
         a.we    = st;
         a.strb  = st ? 4'(((1 << sz) - 1) << addr[1:0]) : 4'b0000;
         a.wdata = (sz == 1) ? d[7:0] * 32'h0101_0101 :
                   (sz == 2) ? d[15:0] * 32'h0001_0001 : d;
         acc_q.push_back(a);
         if (st) begin
            for (int i = 0; i < sz; i++) ref_mem[(32'(addr[5:0]) + i) % 64] = 8'(d >> (8*i));
         end else begin
            val = 0;
            for (int i = 0; i < sz; i++)
               val = val | (32'(ref_mem[(32'(addr[5:0]) + i) % 64]) << (8*i));
            if (f3 < 3'd4 && sz < 4 && val[8*sz - 1]) val = val | (32'hFFFF_FFFF << (8*sz));
            exp_ld = val;
         end
      end
      r.flt = 2'(flt);
      r.ld  = exp_ld;
      resp_q.push_back(r);
      lat      = (flt == 1 || flt == 3) ? 2 : (flt == 2) ? 2 + TMO : 3 + delay;
      nreq_exp = (flt == 1 || flt == 3) ? 0 : (flt == 2) ? TMO : delay + 1;
      cur_delay = delay;
      @(posedge clk);
      #1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = d;
      req_valid  = 1'b1;
      cyc  = 0;
      nreq = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (mem_req) nreq++;
         if (cyc == 1) chk("stall_first", 32'(stall), 1);
      end while (!done && cyc < 30);
      chk("stall_at_done", 32'(stall), 0);
      req_valid = 1'b0;
      chk("latency", cyc, lat);
      chk("mem_req_cycles", nreq, nreq_exp);
   endtask

   initial begin
      req_valid  = 1'b0;
      req_store  = 1'b0;
      req_funct3 = '0;
      req_addr   = '0;
      req_wdata  = '0;
      exp_ld     = '0;
      for (int i = 0; i < 16; i++) set_word(i, $urandom);

      repeat (3) @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_fault", 32'(fault), 0);
      chk("rst_load_data", load_data, 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wstrb", 32'(mem_wstrb), 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_stall", 32'(stall), 0);
      req_valid = 1'b1;
      #1 chk("rst_stall_comb", 32'(stall), 1);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 0);
      chk("sw_mem", bus_mem[0], 32'hDEAD_BEEF);
      set_word(0, 32'h80FF_7F01);
      issue(1'b0, 3'b000, 32'h203, 32'h0, 1);
      chk("lb_value", load_data, 32'hFFFF_FF80);
      issue(1'b0, 3'b100, 32'h203, 32'h0, 0);
      chk("lbu_value", load_data, 32'h0000_0080);
      issue(1'b1, 3'b001, 32'h102, 32'h1234_ABCD, 2);
      chk("sh_mem", bus_mem[0], 32'hABCD_7F01);
      issue(1'b0, 3'b001, 32'h101, 32'h0, 0);
      issue(1'b0, 3'b010, 32'h104, 32'h0, 99);
      issue(1'b0, 3'b010, 32'h10C, 32'h0, TMO - 1);
      issue(1'b1, 3'b100, 32'h0, 32'h55, 0);
      issue(1'b0, 3'b011, 32'h0, 32'h0, 0);
      issue(1'b0, 3'b101, 32'h106, 32'h0, 0);

      cur_delay = 99;
      @(posedge clk);
      #1;
      req_store  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h108;
      req_valid  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_mem_req", 32'(mem_req), 1);
      #2;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("async_rst_mem_req", 32'(mem_req), 0);
      chk("async_rst_done", 32'(done), 0);
      chk("async_rst_stall", 32'(stall), 0);
      chk("async_rst_load_data", load_data, 0);
      exp_ld = '0;
      @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 3'b010, 32'h108, 32'h0, 1);

      for (int n = 0; n < 80; n++) begin
         logic        st;
         logic [2:0]  f3;
         logic [31:0] ad;
         int          dl;
         st = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         ad = 32'h200 + $urandom_range(0, 63);
         if ($urandom_range(0, 1) == 1) ad = ad & 32'hFFFF_FFFC;
         dl = ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(0, TMO - 1);
         issue(st, f3, ad, $urandom, dl);
      end

      repeat (3) @(negedge clk);
      chk("resp_q_drained", resp_q.size(), 0);
      chk("acc_q_drained", acc_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
